// File: rtl/seg_display_engine.sv
// Multi-channel binary-to-decimal seven-segment driver: picks a channel, converts it
// with a bit-serial double-dabble engine and registers the resulting digit image.
module seg_display_engine #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 6,
  parameter int NCH    = 7,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*WIDTH-1:0]    vals,
  input  logic [SEL_W-1:0]        mode,
  input  logic                    signed_en,
  input  logic                    blank_lz,
  output logic [DIGITS*7-1:0]     segs,
  output logic                    busy,
  output logic                    upd,
  output logic [1:0]              fsm_state
);

  localparam int KEY_W = WIDTH + SEL_W + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ERR   = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                state, state_n;
  logic [KEY_W-1:0]      key, snap;
  logic                  snap_valid;
  logic [WIDTH-1:0]      sel_val, mag;
  logic [DIGITS*4-1:0]   bcd, bcd_adj;
  logic                  sticky, neg;
  logic [CNT_W-1:0]      cnt;
  logic [DIGITS*7-1:0]   image;
  logic [SEL_W-1:0]      snap_mode;
  logic                  snap_blank;
  logic                  ovf;
  int                    msd;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Out-of-range selects read as zero so unrelated channel activity never retriggers.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NCH; k++)
      if (int'(mode) == k) sel_val = vals[k*WIDTH +: WIDTH];
  end

  assign key        = {sel_val, mode, signed_en, blank_lz};
  assign snap_mode  = snap[2 +: SEL_W];
  assign snap_blank = snap[0];

  always_comb begin
    for (int d = 0; d < DIGITS; d++)
      bcd_adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!snap_valid || key != snap) state_n = S_LOAD;
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: if (cnt == CNT_W'(1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // A negative value needs a free top digit for its dash, otherwise it is overflow.
  always_comb begin
    msd = 0;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[d*4 +: 4] != 4'd0) msd = d;
    ovf   = sticky || (neg && (bcd[(DIGITS-1)*4 +: 4] != 4'd0));
    image = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (int'(snap_mode) >= NCH)
        image[d*7 +: 7] = SEG_DASH;
      else if (ovf)
        image[d*7 +: 7] = SEG_ERR;
      else if (neg && ((snap_blank && d == msd + 1) || (!snap_blank && d == DIGITS - 1)))
        image[d*7 +: 7] = SEG_DASH;
      else if (snap_blank && d > msd)
        image[d*7 +: 7] = SEG_BLANK;
      else
        image[d*7 +: 7] = seg_code(bcd[d*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      snap       <= '0;
      snap_valid <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      sticky     <= 1'b0;
      neg        <= 1'b0;
      cnt        <= '0;
      segs       <= {DIGITS{SEG_BLANK}};
      upd        <= 1'b0;
    end else begin
      state <= state_n;
      upd   <= 1'b0;
      case (state)
        S_LOAD: begin
          snap       <= key;
          snap_valid <= 1'b1;
          neg        <= signed_en & sel_val[WIDTH-1];
          mag        <= (signed_en & sel_val[WIDTH-1]) ? -sel_val : sel_val;
          bcd        <= '0;
          sticky     <= 1'b0;
          cnt        <= CNT_W'(WIDTH);
        end
        S_SHIFT: begin
          {bcd, mag} <= {bcd_adj[DIGITS*4-2:0], mag, 1'b0};
          sticky     <= sticky | bcd_adj[DIGITS*4-1];
          cnt        <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          segs <= image;
          upd  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_seg_display_engine.sv
// Directed bench for seg_display_engine: default build plus a 20-bit/4-digit build
// for overflow cases; expected digit images are queued and checked on each upd pulse.
module tb_seg_display_engine;

  localparam int NCH = 7;
  localparam int W_A = 12;
  localparam int D_A = 6;
  localparam int W_B = 20;
  localparam int D_B = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH*W_A-1:0] vals_a;
  logic [2:0]         mode_a;
  logic               sen_a, blz_a;
  logic [D_A*7-1:0]   segs_a;
  logic               busy_a, upd_a;
  logic [1:0]         st_a;

  logic [NCH*W_B-1:0] vals_b;
  logic [2:0]         mode_b;
  logic               sen_b, blz_b;
  logic [D_B*7-1:0]   segs_b;
  logic               busy_b, upd_b;
  logic [1:0]         st_b;

  seg_display_engine #(.WIDTH(W_A), .DIGITS(D_A), .NCH(NCH), .SEL_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .vals(vals_a), .mode(mode_a), .signed_en(sen_a),
    .blank_lz(blz_a), .segs(segs_a), .busy(busy_a), .upd(upd_a), .fsm_state(st_a));

  seg_display_engine #(.WIDTH(W_B), .DIGITS(D_B), .NCH(NCH), .SEL_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .vals(vals_b), .mode(mode_b), .signed_en(sen_b),
    .blank_lz(blz_b), .segs(segs_b), .busy(busy_b), .upd(upd_b), .fsm_state(st_b));

  int checks = 0;
  int passes = 0;
  int pops_a = 0;
  int pops_b = 0;
  int upds_a = 0;
  int cyc    = 0;
  int last_upd_cyc_a = 0;

  logic [D_A*7-1:0] exp_a_q[$];
  logic [D_B*7-1:0] exp_b_q[$];
  logic [D_A*7-1:0] mon_exp_a;
  logic [D_B*7-1:0] mon_exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic [D_A*7-1:0] pk6(input logic [6:0] c5, c4, c3, c2, c1, c0);
    return {c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [D_B*7-1:0] pk4(input logic [6:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && upd_a) begin
      upds_a++;
      last_upd_cyc_a = cyc;
      if (exp_a_q.size() == 0) begin
        checks++;
        $display("FAIL upd_a: unexpected pulse with segs %h, required no pulse", segs_a);
      end else begin
        mon_exp_a = exp_a_q.pop_front();
        check("segs_a", 64'(segs_a), 64'(mon_exp_a));
        pops_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && upd_b) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        $display("FAIL upd_b: unexpected pulse with segs %h, required no pulse", segs_b);
      end else begin
        mon_exp_b = exp_b_q.pop_front();
        check("segs_b", 64'(segs_b), 64'(mon_exp_b));
        pops_b++;
      end
    end
  end

  // driver tasks
  task automatic wait_pop_a(input int start, input string name);
    for (int i = 0; i < 60 && pops_a == start; i++) @(posedge clk);
    if (pops_a == start) begin
      checks++;
      $display("FAIL %s: no upd within 60 cycles, required one", name);
      if (exp_a_q.size() > 0) void'(exp_a_q.pop_front());
    end
  endtask

  task automatic wait_pop_b(input int start, input string name);
    for (int i = 0; i < 60 && pops_b == start; i++) @(posedge clk);
    if (pops_b == start) begin
      checks++;
      $display("FAIL %s: no upd within 60 cycles, required one", name);
      if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
    end
  endtask

  task automatic drive_a(input string name, input int ch, input logic [W_A-1:0] v,
                         input logic [2:0] m, input logic s, input logic bl,
                         input logic [D_A*7-1:0] e);
    int start;
    exp_a_q.push_back(e);
    @(negedge clk);
    vals_a[ch*W_A +: W_A] = v;
    mode_a = m;
    sen_a  = s;
    blz_a  = bl;
    start  = pops_a;
    wait_pop_a(start, name);
  endtask

  task automatic drive_b(input string name, input logic [W_B-1:0] v, input logic s,
                         input logic bl, input logic [D_B*7-1:0] e);
    int start;
    exp_b_q.push_back(e);
    @(negedge clk);
    vals_b[0 +: W_B] = v;
    sen_b = s;
    blz_b = bl;
    start = pops_b;
    wait_pop_b(start, name);
  endtask

  initial begin
    int n, start, u, g1, g2;
    rst_n  = 1'b0;
    vals_a = '0; mode_a = 3'd0; sen_a = 1'b0; blz_a = 1'b0;
    vals_b = '0; mode_b = 3'd0; sen_b = 1'b0; blz_b = 1'b0;

    // reset state and first-conversion latency
    repeat (3) @(negedge clk);
    check("reset_segs_a", 64'(segs_a), 64'({D_A{7'h7F}}));
    check("reset_busy_a", 64'(busy_a), 64'd0);
    check("reset_upd_a", 64'(upd_a), 64'd0);
    check("reset_segs_b", 64'(segs_b), 64'({D_B{7'h7F}}));
    exp_a_q.push_back({D_A{7'h40}});
    exp_b_q.push_back({D_B{7'h40}});
    start = pops_a;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (upd_a) break;
    end
    check("first_latency", 64'(n), 64'd15);
    wait_pop_a(start, "first_conv_a");
    drive_a("blank_zero", 0, 12'd0, 3'd0, 1'b0, 1'b1,
            pk6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));

    // unsigned maximum, single update
    u = upds_a;
    drive_a("unsigned_max", 3, 12'd4095, 3'd3, 1'b0, 1'b0,
            pk6(7'h40, 7'h40, 7'h19, 7'h40, 7'h10, 7'h12));
    repeat (30) @(posedge clk);
    check("unsigned_max_once", 64'(upds_a - u), 64'd1);

    // signed values
    drive_a("neg1_blank", 3, 12'hFFF, 3'd3, 1'b1, 1'b1,
            pk6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79));
    drive_a("neg1_noblank", 3, 12'hFFF, 3'd3, 1'b1, 1'b0,
            pk6(7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79));
    drive_a("neg2048", 3, 12'h800, 3'd3, 1'b1, 1'b1,
            pk6(7'h7F, 7'h3F, 7'h24, 7'h40, 7'h19, 7'h00));
    drive_a("pos2048", 3, 12'h800, 3'd3, 1'b0, 1'b1,
            pk6(7'h7F, 7'h7F, 7'h24, 7'h40, 7'h19, 7'h00));

    // out-of-range select ignores the channel values
    drive_a("mode7_dash", 3, 12'h800, 3'd7, 1'b0, 1'b1, {D_A{7'h3F}});
    u = upds_a;
    @(negedge clk);
    vals_a[3*W_A +: W_A] = 12'd1;
    repeat (30) @(posedge clk);
    check("mode7_no_retrigger", 64'(upds_a - u), 64'd0);

    // value change mid-conversion
    exp_a_q.push_back(pk6(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30));
    exp_a_q.push_back(pk6(7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h12, 7'h02));
    @(negedge clk);
    vals_a[1*W_A +: W_A] = 12'd123;
    mode_a = 3'd1;
    start = pops_a;
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_shift", 64'(busy_a), 64'd1);
    @(negedge clk);
    vals_a[1*W_A +: W_A] = 12'd456;
    wait_pop_a(start, "mid_first");
    g1 = last_upd_cyc_a;
    wait_pop_a(start + 1, "mid_second");
    g2 = last_upd_cyc_a - g1;
    checks++;
    if (g2 > 0 && g2 <= W_A + 4) passes++;
    else $display("FAIL mid_gap: got %0d cycles between updates, required 1..%0d", g2, W_A + 4);

    // asynchronous reset during SHIFT
    @(negedge clk);
    vals_a[1*W_A +: W_A] = 12'd789;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_segs_a", 64'(segs_a), 64'({D_A{7'h7F}}));
    check("midreset_busy_a", 64'(busy_a), 64'd0);
    check("midreset_segs_b", 64'(segs_b), 64'({D_B{7'h7F}}));
    exp_a_q.push_back(pk6(7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h00, 7'h10));
    exp_b_q.push_back({D_B{7'h40}});
    start = pops_a;
    n = pops_b;
    @(negedge clk);
    rst_n = 1'b1;
    wait_pop_a(start, "after_midreset_a");
    wait_pop_b(n, "after_midreset_b");

    // overflow on the 20-bit / 4-digit build
    drive_b("ovf_12345", 20'd12345, 1'b0, 1'b0, {D_B{7'h06}});
    drive_b("ovf_neg1234", 20'hFFB2E, 1'b1, 1'b0, {D_B{7'h06}});
    drive_b("max_9999", 20'd9999, 1'b0, 1'b0, {D_B{7'h10}});
    drive_b("neg999", 20'hFFC19, 1'b1, 1'b1, pk4(7'h3F, 7'h10, 7'h10, 7'h10));

    repeat (20) @(posedge clk);
    check("exp_a_drained", 64'(exp_a_q.size()), 64'd0);
    check("exp_b_drained", 64'(exp_b_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
